// File: rtl/rtmc_core_if.sv
// SPI bus bundle for rtmc_core.
//   spi_cs   : chip select, active-low (master -> slave)
//   spi_sclk : serial clock, mode 0     (master -> slave)
//   spi_mosi : serial data, MSB first   (master -> slave)
//   spi_miso : serial data, MSB first   (slave -> master)
interface rtmc_core_if;
  logic spi_cs;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/rtmc_core.sv
// rtmc_core: SPI-controlled register block driving GPIO and a stepper-style
// motor-control output with a one-hot phase sequencer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi        : SPI slave (mode 0, 16-bit frames: R/W, 7-bit address, data)
//   gpi        : general-purpose inputs (synchronized, readable at 0x02)
//   gpo        : general-purpose outputs (register 0x01)
//   mc, mc_oe  : motor-control outputs and their per-bit drive enables
module rtmc_core #(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  rtmc_core_if.slave  spi,
  input  logic [3:0]  gpi,
  output logic [3:0]  gpo,
  output logic [7:0]  mc,
  output logic [7:0]  mc_oe
);

  localparam logic [6:0] ADDR_ID       = 7'h00;
  localparam logic [6:0] ADDR_GPO      = 7'h01;
  localparam logic [6:0] ADDR_GPI      = 7'h02;
  localparam logic [6:0] ADDR_MC_OE    = 7'h03;
  localparam logic [6:0] ADDR_MC_OUT   = 7'h04;
  localparam logic [6:0] ADDR_CTRL     = 7'h05;
  localparam logic [6:0] ADDR_STEP_DIV = 7'h06;
  localparam logic [6:0] ADDR_STEP_POS = 7'h07;

  // Synchronizers
  logic [1:0]  cs_sync_q,   cs_sync_d;
  logic [1:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [3:0]  gpi_meta_q,  gpi_meta_d;
  logic [3:0]  gpi_s_q,     gpi_s_d;
  // SPI frame state
  logic        sclk_prev_q, sclk_prev_d;
  logic        armed_q,     armed_d;
  logic [4:0]  bit_cnt_q,   bit_cnt_d;
  logic [15:0] shift_q,     shift_d;
  logic        read_q,      read_d;
  logic [7:0]  tx_q,        tx_d;
  logic        miso_q,      miso_d;
  logic        commit_q,    commit_d;
  // Register file
  logic [3:0]  gpo_reg_q,   gpo_reg_d;
  logic [7:0]  mc_oe_reg_q, mc_oe_reg_d;
  logic [7:0]  mc_out_q,    mc_out_d;
  logic [1:0]  ctrl_q,      ctrl_d;      // bit0 step_en, bit1 dir
  logic [7:0]  step_div_q,  step_div_d;
  logic [7:0]  step_pos_q,  step_pos_d;
  // Step sequencer
  logic [3:0]  phase_q,     phase_d;
  logic [11:0] presc_q,     presc_d;
  // Registered outputs
  logic [3:0]  gpo_q,       gpo_d;
  logic [7:0]  mc_oe_q,     mc_oe_d;

  logic       cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  assign cs_s      = cs_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Address as it stands once the 8th bit is shifted in (shift_q holds bits 0..6).
  assign rd_addr = {shift_q[5:0], mosi_s};

  always_comb begin
    unique case (rd_addr)
      ADDR_ID:       rd_data = ID_VALUE;
      ADDR_GPO:      rd_data = {4'b0, gpo_reg_q};
      ADDR_GPI:      rd_data = {4'b0, gpi_s_q};
      ADDR_MC_OE:    rd_data = mc_oe_reg_q;
      ADDR_MC_OUT:   rd_data = mc_out_q;
      ADDR_CTRL:     rd_data = {6'b0, ctrl_q};
      ADDR_STEP_DIV: rd_data = step_div_q;
      ADDR_STEP_POS: rd_data = step_pos_q;
      default:       rd_data = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned; that is what keeps it free of inferred latches.
    cs_sync_d   = {cs_sync_q[0], spi.spi_cs};
    sclk_sync_d = {sclk_sync_q[0], spi.spi_sclk};
    mosi_sync_d = {mosi_sync_q[0], spi.spi_mosi};
    gpi_meta_d  = gpi;
    gpi_s_d     = gpi_meta_q;
    sclk_prev_d = sclk_s;
    armed_d     = armed_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    read_d      = read_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    commit_d    = 1'b0;
    gpo_reg_d   = gpo_reg_q;
    mc_oe_reg_d = mc_oe_reg_q;
    mc_out_d    = mc_out_q;
    ctrl_d      = ctrl_q;
    step_div_d  = step_div_q;
    step_pos_d  = step_pos_q;
    phase_d     = phase_q;
    presc_d     = presc_q;
    gpo_d       = gpo_reg_q;
    mc_oe_d     = mc_oe_reg_q;

    // Frames are only accepted after cs has been seen high since reset, so a
    // frame interrupted by reset is ignored until the master re-selects.
    if (cs_s) begin
      armed_d   = 1'b1;
      bit_cnt_d = '0;
      read_d    = 1'b0;
      miso_d    = 1'b0;
    end else if (armed_q) begin
      if (sclk_rise && bit_cnt_q < 5'd16) begin
        shift_d   = {shift_q[14:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd7) begin
          read_d = shift_q[6];
          tx_d   = rd_data;
        end
        if (bit_cnt_q == 5'd15) begin
          commit_d = 1'b1;
          read_d   = 1'b0;
          miso_d   = 1'b0;
        end
      end
      if (sclk_fall && read_q && bit_cnt_q >= 5'd8 && bit_cnt_q <= 5'd15) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end

    // Step sequencer: one step when the prescaler reaches (STEP_DIV+1)*16-1.
    if (!ctrl_q[0]) begin
      presc_d = '0;
    end else if (presc_q == {step_div_q, 4'hF}) begin
      presc_d = '0;
      if (ctrl_q[1]) begin
        phase_d    = {phase_q[0], phase_q[3:1]};
        step_pos_d = step_pos_q - 8'd1;
      end else begin
        phase_d    = {phase_q[2:0], phase_q[3]};
        step_pos_d = step_pos_q + 8'd1;
      end
    end else begin
      presc_d = presc_q + 12'd1;
    end

    // Write commit one cycle after the 16th bit; the frame stays in shift_q
    // because bits past 16 are not shifted.
    if (commit_q && !shift_q[15]) begin
      unique case (shift_q[14:8])
        ADDR_GPO:      gpo_reg_d   = shift_q[3:0];
        ADDR_MC_OE:    mc_oe_reg_d = shift_q[7:0];
        ADDR_MC_OUT:   mc_out_d    = shift_q[7:0];
        ADDR_CTRL:     ctrl_d      = shift_q[1:0];
        ADDR_STEP_DIV: begin
          step_div_d = shift_q[7:0];
          presc_d    = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // cs synchronizer resets to "selected" so armed_q only sets once the
      // pin is genuinely seen high after reset.
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      gpi_meta_q  <= '0;
      gpi_s_q     <= '0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      read_q      <= 1'b0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      commit_q    <= 1'b0;
      gpo_reg_q   <= '0;
      mc_oe_reg_q <= '0;
      mc_out_q    <= '0;
      ctrl_q      <= '0;
      step_div_q  <= 8'hFF;
      step_pos_q  <= '0;
      phase_q     <= 4'b0001;
      presc_q     <= '0;
      gpo_q       <= '0;
      mc_oe_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      gpi_meta_q  <= gpi_meta_d;
      gpi_s_q     <= gpi_s_d;
      sclk_prev_q <= sclk_prev_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      read_q      <= read_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      commit_q    <= commit_d;
      gpo_reg_q   <= gpo_reg_d;
      mc_oe_reg_q <= mc_oe_reg_d;
      mc_out_q    <= mc_out_d;
      ctrl_q      <= ctrl_d;
      step_div_q  <= step_div_d;
      step_pos_q  <= step_pos_d;
      phase_q     <= phase_d;
      presc_q     <= presc_d;
      gpo_q       <= gpo_d;
      mc_oe_q     <= mc_oe_d;
    end
  end

  assign gpo          = gpo_q;
  assign mc_oe        = mc_oe_q;
  assign mc           = ctrl_q[0] ? {mc_out_q[7:4], phase_q} : mc_out_q;
  assign spi.spi_miso = miso_q;

endmodule

// File: tb/tb_rtmc_core.sv
module tb_rtmc_core;
  localparam int H = 40;  // sclk half period: clk/8
  localparam int G = 60;  // cs-high gap between frames

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gpi;
  logic [3:0] gpo;
  logic [7:0] mc;
  logic [7:0] mc_oe;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  rtmc_core_if spi_bus ();

  rtmc_core #(.ID_VALUE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (spi_bus),
    .gpi   (gpi),
    .gpo   (gpo),
    .mc    (mc),
    .mc_oe (mc_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time exceeded, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_bus.spi_mosi = b;
    #H;
    m = spi_bus.spi_miso;
    spi_bus.spi_sclk = 1'b1;
    #H;
    spi_bus.spi_sclk = 1'b0;
  endtask

  // Read data is captured before rising edges 9..16; every other sample
  // point (and after cs rises) must see miso low.
  task automatic spi_frame(input logic [15:0] f, input int nbits,
                           output logic [7:0] rd, output logic noisy);
    logic m, b;
    rd = '0;
    noisy = 1'b0;
    spi_bus.spi_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? f[4'(15 - i)] : 1'b1;
      spi_bit(b, m);
      if (f[15] && i >= 8 && i < 16) rd = {rd[6:0], m};
      else if (m !== 1'b0) noisy = 1'b1;
    end
    #H;
    if (spi_bus.spi_miso !== 1'b0) noisy = 1'b1;
    spi_bus.spi_cs = 1'b1;
    #G;
    if (spi_bus.spi_miso !== 1'b0) noisy = 1'b1;
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic noisy;
    spi_frame({1'b0, a, d}, 16, rd, noisy);
    n_checks++;
    if (noisy !== 1'b0) $display("FAIL write_miso_quiet addr=%h: miso active=%b, required 0", a, noisy);
    else n_pass++;
  endtask

  task automatic spi_read(input logic [6:0] a, input logic [7:0] e);
    logic [7:0] rd, exp;
    logic noisy;
    exp_q.push_back(e);
    spi_frame({1'b1, a, 8'h00}, 16, rd, noisy);
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) $display("FAIL read addr=%h: got %h, required %h", a, rd, exp);
    else n_pass++;
    n_checks++;
    if (noisy !== 1'b0) $display("FAIL read_miso_quiet addr=%h: miso active=%b, required 0", a, noisy);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [15:0] hdr, post;
    logic m;
    rst_n = 1'b0;
    spi_bus.spi_cs = 1'b1;
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_mosi = 1'b0;
    gpi = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gpo, mc, mc_oe, spi_bus.spi_miso} !== 21'h0)
      $display("FAIL reset_outputs: got %h, required 0", {gpo, mc, mc_oe, spi_bus.spi_miso});
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    spi_write(7'h01, 8'h0F);
    spi_write(7'h03, 8'hFF);
    spi_write(7'h04, 8'h55);
    n_checks++;
    if ({gpo, mc_oe, mc} !== {4'hF, 8'hFF, 8'h55})
      $display("FAIL pre_reset_outputs: got %h, required %h", {gpo, mc_oe, mc}, {4'hF, 8'hFF, 8'h55});
    else n_pass++;

    // Reset in the middle of a read frame of STEP_DIV.
    hdr = {1'b1, 7'h06, 8'h00};
    spi_bus.spi_cs = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(hdr[4'(15 - i)], m);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gpo, mc, mc_oe, spi_bus.spi_miso} !== 21'h0)
      $display("FAIL midframe_reset_outputs: got %h, required 0", {gpo, mc, mc_oe, spi_bus.spi_miso});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A whole write clocked while cs never rose after reset must be ignored.
    post = {1'b0, 7'h01, 8'h0F};
    for (int i = 0; i < 16; i++) spi_bit(post[4'(15 - i)], m);
    #H;
    spi_bus.spi_cs = 1'b1;
    #G;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({gpo, mc_oe} !== 12'h0)
      $display("FAIL frame_after_reset_ignored: got %h, required 0", {gpo, mc_oe});
    else n_pass++;
    spi_read(7'h06, 8'hFF);
    spi_read(7'h01, 8'h00);
  endtask

  task automatic test_id();
    spi_read(7'h00, 8'hA5);
  endtask

  task automatic test_gpio();
    logic [7:0] rd;
    logic noisy;
    spi_write(7'h01, 8'h05);
    n_checks++;
    if (gpo !== 4'b0101) $display("FAIL gpo_write: got %b, required 0101", gpo);
    else n_pass++;
    gpi = 4'b1001;
    repeat (4) @(negedge clk);
    spi_read(7'h02, 8'h09);
    spi_read(7'h01, 8'h05);
    // 20-bit frame: the trailing bits are ignored.
    spi_frame({1'b0, 7'h01, 8'h0A}, 20, rd, noisy);
    n_checks++;
    if ({gpo, noisy} !== {4'hA, 1'b0})
      $display("FAIL long_frame: got gpo=%h miso_active=%b, required gpo=a miso_active=0", gpo, noisy);
    else n_pass++;
  endtask

  task automatic test_mc();
    logic [7:0] rd;
    logic noisy;
    spi_write(7'h03, 8'hFF);
    spi_write(7'h04, 8'h3C);
    n_checks++;
    if ({mc_oe, mc} !== {8'hFF, 8'h3C})
      $display("FAIL mc_write: got mc_oe=%h mc=%h, required ff 3c", mc_oe, mc);
    else n_pass++;
    spi_frame({1'b0, 7'h04, 8'h00}, 10, rd, noisy);
    repeat (4) @(negedge clk);
    n_checks++;
    if (mc !== 8'h3C) $display("FAIL aborted_write: got mc=%h, required 3c", mc);
    else n_pass++;
    spi_read(7'h04, 8'h3C);
    spi_write(7'h40, 8'h77);
    spi_read(7'h40, 8'h00);
    spi_write(7'h00, 8'h00);
    spi_read(7'h00, 8'hA5);
    spi_write(7'h07, 8'h33);
    spi_read(7'h07, 8'h00);
    spi_write(7'h05, 8'hFC);
    spi_read(7'h05, 8'h00);
  endtask

  task automatic test_step();
    logic [7:0] vals [5];
    logic [7:0] exp_seq [5];
    int stamps [5];
    int n = 0;
    int cyc = 0;
    logic [7:0] last;
    exp_seq = '{8'hA1, 8'hA2, 8'hA4, 8'hA8, 8'hA1};
    spi_write(7'h06, 8'h00);
    spi_write(7'h04, 8'hA0);
    n_checks++;
    if (mc !== 8'hA0) $display("FAIL mc_before_step: got %h, required a0", mc);
    else n_pass++;
    last = mc;
    fork
      begin
        spi_write(7'h05, 8'h01);
        spi_read(7'h07, 8'h04);  // latched after the 4th step, before the 5th
      end
      begin
        while (n < 5 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (mc !== last) begin
            vals[n] = mc;
            stamps[n] = cyc;
            n++;
            last = mc;
          end
        end
      end
    join
    n_checks++;
    if (n !== 5) $display("FAIL step_count: got %0d mc changes, required 5", n);
    else n_pass++;
    for (int k = 0; k < n; k++) begin
      n_checks++;
      if (vals[k] !== exp_seq[k]) $display("FAIL step_mc[%0d]: got %h, required %h", k, vals[k], exp_seq[k]);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (stamps[k] - stamps[k-1] !== 16)
          $display("FAIL step_interval[%0d]: got %0d cycles, required 16", k, stamps[k] - stamps[k-1]);
        else n_pass++;
      end
    end
    spi_write(7'h05, 8'h00);
    n_checks++;
    if (mc !== 8'hA0) $display("FAIL step_disabled: got %h, required a0", mc);
    else n_pass++;
  endtask

  task automatic test_dir();
    logic [7:0] vals [2];
    int stamps [2];
    int n = 0;
    int cyc = 0;
    logic [7:0] last;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    last = mc;
    fork
      spi_write(7'h05, 8'h03);
      begin
        while (n < 2 && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          if (mc !== last) begin
            vals[n] = mc;
            stamps[n] = cyc;
            n++;
            last = mc;
          end
        end
      end
    join
    n_checks++;
    if (n !== 2) $display("FAIL dir_change_count: got %0d mc changes, required 2", n);
    else n_pass++;
    if (n == 2) begin
      n_checks++;
      if ({vals[0], vals[1]} !== {8'h01, 8'h08})
        $display("FAIL dir_phase: got %h then %h, required 01 then 08", vals[0], vals[1]);
      else n_pass++;
      n_checks++;
      if (stamps[1] - stamps[0] !== 4096)
        $display("FAIL first_step_delay: got %0d cycles, required 4096", stamps[1] - stamps[0]);
      else n_pass++;
    end
    spi_read(7'h07, 8'hFF);
    spi_write(7'h05, 8'h00);
    spi_read(7'h07, 8'hFF);
  endtask

  initial begin
    test_reset();
    test_id();
    test_gpio();
    test_mc();
    test_step();
    test_dir();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtmc_core.md
RTMC_CORE -- requirements
Module: rtmc_core

Interface
REQ-001 SHALL have parameter ID_VALUE, default 8'hA5, the constant returned when register 0x00 is read.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port spi_cs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk, at most clk/8.
REQ-006 SHALL have port spi_mosi  input  1  SPI data in, MSB first.
REQ-007 SHALL have port spi_miso  output  1  SPI data out, MSB first.
REQ-008 SHALL have port gpi  input  4  general-purpose inputs.
REQ-009 SHALL have port gpo  output  4  general-purpose outputs.
REQ-010 SHALL have port mc  output  8  motor-control outputs.
REQ-011 SHALL have port mc_oe  output  8  per-bit output enables for mc, 1 = drive.

Function
REQ-012 SHALL pass spi_cs, spi_sclk, spi_mosi and gpi through 2-flop synchronizers before use; SPI edges detected from synchronized spi_sclk.
REQ-013 SHALL frame transactions as 16 bits while synchronized spi_cs low: bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data.
REQ-014 SHALL sample spi_mosi on detected rising sclk edges; bit counter cleared whenever synchronized spi_cs is high.
REQ-015 SHALL on a read frame latch register[address] at the 8th rising edge and shift it out MSB first, updating spi_miso after each detected falling sclk edge so bit7 is valid before rising edge 9.
REQ-016 SHALL drive spi_miso 0 when cs high, during bits 0-7, during write frames, and after bit 16.
REQ-017 SHALL commit a write in the clk cycle after the 16th detected rising edge; frames aborted (cs high) before 16 bits write nothing; bits beyond 16 ignored until cs returns high.
REQ-018 SHALL implement registers: 0x00 ID (RO, ID_VALUE); 0x01 GPO (RW, bits3:0); 0x02 GPI (RO, {4'b0, synchronized gpi}); 0x03 MC_OE (RW); 0x04 MC_OUT (RW); 0x05 CTRL (RW: bit0 step_en, bit1 dir, bits7:2 read 0); 0x06 STEP_DIV (RW); 0x07 STEP_POS (RO).
REQ-019 SHALL read 0x00 from unmapped addresses and ignore writes to them and to RO registers.
REQ-020 SHALL drive gpo = GPO[3:0] and mc_oe = MC_OE, registered, updating the clk cycle after commit.
REQ-021 SHALL drive mc = MC_OUT when step_en = 0; when step_en = 1, mc[7:4] = MC_OUT[7:4] and mc[3:0] = one-hot phase register.
REQ-022 SHALL advance the step sequencer once every (STEP_DIV+1)*16 clk cycles while step_en = 1; prescaler cleared when step_en = 0 or on any write to STEP_DIV.
REQ-023 SHALL on each step rotate phase left (0001->0010->0100->1000->0001) and increment STEP_POS when dir = 0, rotate right and decrement STEP_POS when dir = 1; STEP_POS wraps modulo 256.
REQ-024 SHALL first step exactly (STEP_DIV+1)*16 cycles after step_en set; phase and STEP_POS held while step_en = 0.

Reset
REQ-025 SHALL on rst_n low immediately force: gpo = 0, mc = 0, mc_oe = 0, spi_miso = 0, GPO/MC_OE/MC_OUT/CTRL/STEP_POS = 0, STEP_DIV = 0xFF, phase = 4'b0001, bit counter and prescaler = 0.
REQ-026 SHALL discard any in-progress SPI frame on reset; first frame after rst_n release begins at the next cs falling edge.

Verification
REQ-027 SHALL pass: reset asserted mid-frame -> all outputs 0, read of 0x06 after release returns 0xFF.
REQ-028 SHALL pass: read frame addr 0x00 -> spi_miso shifts 1010_0101 (0xA5).
REQ-029 SHALL pass: write 0x01 = 0x05, then gpi = 4'b1001 and read 0x02 -> gpo = 4'b0101, miso returns 0x09.
REQ-030 SHALL pass: write 0x03 = 0xFF, 0x04 = 0x3C -> mc_oe = 0xFF, mc = 0x3C; cs raised after 10 bits of a write 0x04 = 0x00 -> mc stays 0x3C.
REQ-031 SHALL pass: STEP_DIV = 0, MC_OUT = 0xA0, CTRL = 0x01 -> mc = 0xA1, 0xA2, 0xA4, 0xA8, 0xA1 at 16-cycle intervals; STEP_POS reads 4.
REQ-032 SHALL pass: CTRL = 0x03 from reset -> phase 1000 after first step, STEP_POS reads 0xFF (wrap).
